// File: rtl/quan_pkg.sv
// Shared types and constants for the serial ADPCM quantizer: rate codes, FSM states,
// per-rate threshold counts, the ascending decision thresholds and the codeword mapping.
package quan_pkg;

  typedef enum logic [1:0] {
    RATE_40 = 2'd0,
    RATE_32 = 2'd1,
    RATE_24 = 2'd2,
    RATE_16 = 2'd3
  } rate_e;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam logic [3:0] N_40 = 4'd15;
  localparam logic [3:0] N_32 = 4'd7;
  localparam logic [3:0] N_24 = 4'd3;
  localparam logic [3:0] N_16 = 4'd1;

  typedef logic [11:0] thr_tbl_t [16];

  // Unused tail entries are zero; the scan never reaches past entry N-1.
  localparam thr_tbl_t THR_40 = '{
    -12'sd122, -12'sd16, 12'd68,  12'd139, 12'd198, 12'd250, 12'd298, 12'd339,
    12'd378,   12'd413,  12'd445, 12'd475, 12'd502, 12'd528, 12'd553, 12'd0
  };
  localparam thr_tbl_t THR_32 = '{
    -12'sd124, 12'd80, 12'd178, 12'd246, 12'd300, 12'd349, 12'd400, 12'd0,
    12'd0,     12'd0,  12'd0,   12'd0,   12'd0,   12'd0,   12'd0,   12'd0
  };
  localparam thr_tbl_t THR_24 = '{
    12'd8, 12'd218, 12'd331, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0,
    12'd0, 12'd0,   12'd0,   12'd0, 12'd0, 12'd0, 12'd0, 12'd0
  };
  localparam thr_tbl_t THR_16 = '{
    12'd261, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0,
    12'd0,   12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0
  };

  function automatic logic [3:0] rate_n(rate_e r);
    case (r)
      RATE_40: return N_40;
      RATE_32: return N_32;
      RATE_24: return N_24;
      default: return N_16;
    endcase
  endfunction

  // {N,1} is 2N+1: the all-ones code that stands for the zero-magnitude bin.
  function automatic logic [4:0] codeword(rate_e r, logic [3:0] mag, logic ds);
    logic [4:0] top;
    top = {rate_n(r), 1'b1};
    if (ds)
      return top - {1'b0, mag};
    else if (mag == 4'd0)
      return top;
    else
      return {1'b0, mag};
  endfunction

endpackage

// File: rtl/quan_serial_if.sv
// Request/result bundle of the serial quantizer: START with its operands in, BUSY/DONE/I out.
interface quan_serial_if;
  logic        START;
  logic [1:0]  RATE;
  logic [11:0] DLN;
  logic        DS;
  logic        BUSY;
  logic        DONE;
  logic [4:0]  I;

  modport master (output START, RATE, DLN, DS, input BUSY, DONE, I);
  modport slave  (input START, RATE, DLN, DS, output BUSY, DONE, I);
endinterface

// File: rtl/quan_thresh_rom.sv
// Combinational threshold lookup: (rate, idx) -> signed 12-bit threshold plus a flag
// marking the last threshold of that rate.
module quan_thresh_rom
  import quan_pkg::*;
(
  input  rate_e       rate,
  input  logic [3:0]  idx,
  output logic [11:0] thresh,
  output logic        last
);

  always_comb begin
    thresh = '0;
    case (rate)
      RATE_40: thresh = THR_40[idx];
      RATE_32: thresh = THR_32[idx];
      RATE_24: thresh = THR_24[idx];
      default: thresh = THR_16[idx];
    endcase
    last = (idx == rate_n(rate) - 4'd1);
  end

endmodule

// File: rtl/quan_serial.sv
// Serial adaptive quantizer: one threshold compare per clock, DONE pulses with codeword I.
// Optional QUAN_EARLY_EXIT_EN ends the scan at the first failing compare.
module quan_serial
  import quan_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET_N,
  quan_serial_if.slave  bus
);

  state_e      state;
  rate_e       rate_q;
  logic [11:0] dln_q;
  logic        ds_q;
  logic [3:0]  idx;
  logic [3:0]  mag;
  logic        busy_q;
  logic        done_q;
  logic [4:0]  i_q;

  logic [11:0] thresh;
  logic        last;
  logic        pass;
  logic [3:0]  mag_inc;
  logic        finish;

  quan_thresh_rom u_rom (
    .rate   (rate_q),
    .idx    (idx),
    .thresh (thresh),
    .last   (last)
  );

  assign pass    = $signed(dln_q) >= $signed(thresh);
  assign mag_inc = mag + {3'b000, pass};

`ifdef QUAN_EARLY_EXIT_EN
  // Thresholds ascend, so after one failure no later compare can pass.
  assign finish = last | ~pass;
`else
  assign finish = last;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= IDLE;
      rate_q <= RATE_40;
      dln_q  <= '0;
      ds_q   <= 1'b0;
      idx    <= '0;
      mag    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      i_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.START) begin
            rate_q <= rate_e'(bus.RATE);
            dln_q  <= bus.DLN;
            ds_q   <= bus.DS;
            idx    <= '0;
            mag    <= '0;
            busy_q <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          mag <= mag_inc;
          if (finish) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            i_q    <= codeword(rate_q, mag_inc, ds_q);
          end else begin
            idx <= idx + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.I    = i_q;

endmodule

// File: tb/tb_quan_serial.sv
// Directed vector bench for quan_serial: codeword, latency and handshake corner cases.
module tb_quan_serial;

  logic CLK;
  logic RESET_N;
  int   total;
  int   bad;

  quan_serial_if bus ();

  quan_serial dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  rate;
    logic [11:0] dln;
    logic        ds;
    int          exp_i;
    int          exp_mag;
    int          n;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input int mag, input int n);
`ifdef QUAN_EARLY_EXIT_EN
    return (mag + 1 > n) ? n : mag + 1;
`else
    return n;
`endif
  endfunction

  // Issues one request, then counts edges after e0 until DONE is seen.
  task automatic run_op(input logic [1:0] rate, input logic [11:0] dln, input logic ds,
                        output int lat, output int ival, output int busy0);
    @(negedge CLK);
    bus.RATE  = rate;
    bus.DLN   = dln;
    bus.DS    = ds;
    bus.START = 1'b1;
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
    busy0 = int'(bus.BUSY);
    lat   = -1;
    ival  = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge CLK);
      #1;
      if (bus.DONE) begin
        lat  = k;
        ival = int'(bus.I);
        break;
      end
    end
  endtask

  initial begin
    int lat, ival, busy0, dcount, last_i;
    total = 0;
    bad   = 0;

    vecs[0]  = '{2'd1, 12'd200,  1'b0, 3,  3,  7};
    vecs[1]  = '{2'd1, 12'd200,  1'b1, 12, 3,  7};
    vecs[2]  = '{2'd1, 12'hF38,  1'b0, 15, 0,  7};
    vecs[3]  = '{2'd1, 12'hF38,  1'b1, 15, 0,  7};
    vecs[4]  = '{2'd0, 12'd600,  1'b0, 15, 15, 15};
    vecs[5]  = '{2'd0, 12'd600,  1'b1, 16, 15, 15};
    vecs[6]  = '{2'd0, 12'hFF0,  1'b0, 2,  2,  15};
    vecs[7]  = '{2'd3, 12'd261,  1'b0, 1,  1,  1};
    vecs[8]  = '{2'd3, 12'd260,  1'b0, 3,  0,  1};
    vecs[9]  = '{2'd3, 12'd261,  1'b1, 2,  1,  1};
    vecs[10] = '{2'd2, 12'd331,  1'b1, 4,  3,  3};
    vecs[11] = '{2'd0, 12'h800,  1'b0, 31, 0,  15};
    vecs[12] = '{2'd0, 12'h7FF,  1'b1, 16, 15, 15};
    vecs[13] = '{2'd2, 12'd8,    1'b0, 1,  1,  3};
    vecs[14] = '{2'd1, 12'h7FF,  1'b0, 7,  7,  7};

    bus.START = 1'b0;
    bus.RATE  = 2'd0;
    bus.DLN   = 12'd0;
    bus.DS    = 1'b0;
    RESET_N   = 1'b0;
    #12;
    chk("reset_busy", int'(bus.BUSY), 0);
    chk("reset_done", int'(bus.DONE), 0);
    chk("reset_i",    int'(bus.I),    0);
    @(negedge CLK);
    RESET_N = 1'b1;

    foreach (vecs[v]) begin
      run_op(vecs[v].rate, vecs[v].dln, vecs[v].ds, lat, ival, busy0);
      chk($sformatf("v%0d_busy", v), busy0, 1);
      chk($sformatf("v%0d_i", v),    ival,  vecs[v].exp_i);
      chk($sformatf("v%0d_lat", v),  lat,   exp_lat(vecs[v].exp_mag, vecs[v].n));
    end

    // START pulses during BUSY must be ignored.
    @(negedge CLK);
    bus.RATE = 2'd0; bus.DLN = 12'd600; bus.DS = 1'b0; bus.START = 1'b1;
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
    dcount = 0;
    last_i = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (c == 1 || c == 2) begin
        bus.START = 1'b1; bus.RATE = 2'd3; bus.DLN = 12'd0;
      end else begin
        bus.START = 1'b0;
      end
      @(posedge CLK);
      #1;
      if (bus.DONE) begin
        dcount++;
        last_i = int'(bus.I);
      end
    end
    chk("busy_start_done_count", dcount, 1);
    chk("busy_start_i", last_i, 15);

    // START held through DONE: second request accepted with no gap; mid-scan input changes ignored.
    @(negedge CLK);
    bus.RATE = 2'd2; bus.DLN = 12'd331; bus.DS = 1'b1; bus.START = 1'b1;
    @(posedge CLK);
    #1;
    bus.RATE = 2'd3; bus.DLN = 12'd261; bus.DS = 1'b0;
    lat = -1;
    ival = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge CLK);
      #1;
      if (bus.DONE) begin
        lat = k;
        ival = int'(bus.I);
        break;
      end
    end
    chk("b2b_first_i", ival, 4);
    chk("b2b_first_lat", lat, exp_lat(3, 3));
    chk("b2b_done_cycle_busy", int'(bus.BUSY), 0);
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
    chk("b2b_accept_busy", int'(bus.BUSY), 1);
    chk("b2b_accept_done", int'(bus.DONE), 0);
    @(posedge CLK);
    #1;
    chk("b2b_second_done", int'(bus.DONE), 1);
    chk("b2b_second_i", int'(bus.I), 1);

    // Asynchronous reset in the middle of a RATE 0 scan.
    @(negedge CLK);
    bus.RATE = 2'd0; bus.DLN = 12'd600; bus.DS = 1'b0; bus.START = 1'b1;
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #3;
    RESET_N = 1'b0;
    #1;
    chk("abort_busy", int'(bus.BUSY), 0);
    chk("abort_done", int'(bus.DONE), 0);
    chk("abort_i",    int'(bus.I),    0);
    @(negedge CLK);
    RESET_N = 1'b1;
    dcount = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK);
      #1;
      if (bus.DONE) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    run_op(2'd1, 12'd200, 1'b0, lat, ival, busy0);
    chk("after_abort_i", ival, 3);
    chk("after_abort_lat", lat, exp_lat(3, 7));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
